// File: rtl/i2c_pkg.sv
// Shared widths, FSM encoding and direction constants for the I2C master arbiter slice.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Command/response bundle between the arbiter and the shared I2C master core.
interface i2c_master_arbiter_if;
    import i2c_pkg::*;

    logic              m_en;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_data_in;
    logic              m_read_write;
    logic [DATA_W-1:0] m_data_out;
    logic              m_done;

    // Arbiter side: issues the command and waits for the completion pulse.
    modport master (
        output m_en, m_address, m_data_in, m_read_write,
        input  m_data_out, m_done
    );

    modport slave (
        input  m_en, m_address, m_data_in, m_read_write,
        output m_data_out, m_done
    );

endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = '0;
        // Extra sum bit keeps ptr+i from wrapping before the modulo step.
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= NUM_W) pos = pos - NUM_W;
            if (!valid && req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        winner = NUM_REQ'(valid) << idx;
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master between NUM_REQ requesters.
// Optional transaction abort on timeout when I2C_ARB_TIMEOUT_EN is defined.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [ADDR_W*NUM_REQ-1:0] req_address,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_read_write,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      err,
    i2c_master_arbiter_if.master      bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [ADDR_W-1:0]  sel_address;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_rw;
    logic               tmo_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (arb_winner),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        sel_rw      = RW_WRITE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_address = req_address[i*ADDR_W +: ADDR_W];
                sel_data    = req_data[i*DATA_W +: DATA_W];
                sel_rw      = req_read_write[i];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt;

    // Held at zero outside BUSY, so it starts clean on every BUSY entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_BUSY) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == ST_BUSY) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            ptr              <= IDX_W'(NUM_REQ - 1);
            grant            <= '0;
            done             <= '0;
            rd_data          <= '0;
            err              <= 1'b0;
            bus.m_en         <= 1'b0;
            bus.m_address    <= '0;
            bus.m_data_in    <= '0;
            bus.m_read_write <= RW_WRITE;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant            <= arb_winner;
                        ptr              <= arb_idx;
                        bus.m_en         <= 1'b1;
                        bus.m_address    <= sel_address;
                        bus.m_data_in    <= sel_data;
                        bus.m_read_write <= sel_rw;
                        state            <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (bus.m_done) begin
                        if (bus.m_read_write == RW_READ) rd_data <= bus.m_data_out;
                        done     <= grant;
                        grant    <= '0;
                        bus.m_en <= 1'b0;
                        state    <= ST_DONE;
                    end else if (tmo_hit) begin
                        done     <= grant;
                        err      <= 1'b1;
                        grant    <= '0;
                        bus.m_en <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares them. Timeout checks follow I2C_ARB_TIMEOUT_EN.
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] req_address;
    logic [15:0] req_data;
    logic [1:0]  req_read_write;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [7:0]  rd_data;
    logic        err;

    i2c_master_arbiter_if bus ();

    i2c_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_read_write (req_read_write),
        .grant          (grant),
        .done           (done),
        .rd_data        (rd_data),
        .err            (err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] g;
        logic [6:0] a;
        logic [7:0] d;
        logic       rw;
    } gexp_t;

    typedef struct packed {
        logic [1:0] dn;
        logic [7:0] rd;
        logic       e;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks each new grant and each completion against the queues.
    gexp_t      g;
    dexp_t      d;
    logic       prev_en   = 1'b0;
    logic [1:0] prev_done = 2'b00;

    always @(negedge clk) begin
        if (bus.m_en && !prev_en) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 32'(0));
            end else begin
                g = gq.pop_front();
                chk("grant", 32'(grant), 32'(g.g));
                chk("m_address", 32'(bus.m_address), 32'(g.a));
                chk("m_data_in", 32'(bus.m_data_in), 32'(g.d));
                chk("m_read_write", 32'(bus.m_read_write), 32'(g.rw));
            end
        end
        if (done != 2'b00) begin
            chk("done_one_cycle", 32'(prev_done), 32'(0));
            chk("grant_cleared", 32'(grant), 32'(0));
            chk("m_en_cleared", 32'(bus.m_en), 32'(0));
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                d = dq.pop_front();
                chk("done", 32'(done), 32'(d.dn));
                chk("rd_data", 32'(rd_data), 32'(d.rd));
                chk("err", 32'(err), 32'(d.e));
            end
        end
        prev_en   = bus.m_en;
        prev_done = done;
    end

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] dt, input logic rw);
        req_address[i*7 +: 7] = a;
        req_data[i*8 +: 8]    = dt;
        req_read_write[i]     = rw;
    endtask

    task automatic push_g(input logic [1:0] gv, input logic [6:0] a, input logic [7:0] dt, input logic rw);
        gexp_t e;
        e.g = gv; e.a = a; e.d = dt; e.rw = rw;
        gq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] dv, input logic [7:0] rd, input logic e);
        dexp_t x;
        x.dn = dv; x.rd = rd; x.e = e;
        dq.push_back(x);
    endtask

    task automatic wait_grant();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_en && n < 20);
        chk("grant_wait", 32'(bus.m_en), 32'(1));
    endtask

    task automatic pulse_done(input logic [7:0] dout, input logic [1:0] drop);
        @(posedge clk); #1;
        bus.m_data_out = dout;
        bus.m_done     = 1'b1;
        @(posedge clk); #1;
        bus.m_done = 1'b0;
        req        = req & ~drop;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req            = 2'b00;
        req_address    = '0;
        req_data       = '0;
        req_read_write = '0;
        bus.m_done     = 1'b0;
        bus.m_data_out = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_m_en", 32'(bus.m_en), 32'(0));
        chk("rst_m_address", 32'(bus.m_address), 32'(0));
        chk("rst_m_data_in", 32'(bus.m_data_in), 32'(0));
        chk("rst_m_read_write", 32'(bus.m_read_write), 32'(0));

        // Single write from requester 0, one-cycle grant latency
        set_req(0, 7'd48, 8'h0C, 1'b0);
        push_g(2'b01, 7'd48, 8'h0C, 1'b0);
        req = 2'b01;
        @(posedge clk); #1;
        chk("grant_latency", 32'(bus.m_en), 32'(1));
        repeat (20) @(posedge clk);
        push_d(2'b01, 8'h00, 1'b0);
        pulse_done(8'h5E, 2'b01);

        // Read from requester 1
        set_req(1, 7'h35, 8'h00, 1'b1);
        push_g(2'b10, 7'h35, 8'h00, 1'b1);
        req = 2'b10;
        wait_grant();
        repeat (5) @(posedge clk);
        push_d(2'b10, 8'hA5, 1'b0);
        pulse_done(8'hA5, 2'b10);
        repeat (3) @(negedge clk);
        chk("rd_data_hold", 32'(rd_data), 32'(8'hA5));

        // Fairness with both requesters held; writes must not disturb rd_data
        set_req(0, 7'h11, 8'h22, 1'b0);
        set_req(1, 7'h33, 8'h44, 1'b0);
        push_g(2'b01, 7'h11, 8'h22, 1'b0);
        push_g(2'b10, 7'h33, 8'h44, 1'b0);
        push_g(2'b01, 7'h11, 8'h22, 1'b0);
        push_g(2'b10, 7'h33, 8'h44, 1'b0);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            repeat (3) @(posedge clk);
            push_d((k % 2 == 0) ? 2'b01 : 2'b10, 8'hA5, 1'b0);
            pulse_done(8'h77, (k == 3) ? 2'b11 : 2'b00);
        end

        // Request inputs change and req drops mid-transaction
        set_req(0, 7'h2A, 8'h5A, 1'b0);
        push_g(2'b01, 7'h2A, 8'h5A, 1'b0);
        req = 2'b01;
        wait_grant();
        set_req(0, 7'h7F, 8'hFF, 1'b1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("noise_m_address", 32'(bus.m_address), 32'(7'h2A));
        chk("noise_m_data_in", 32'(bus.m_data_in), 32'(8'h5A));
        chk("noise_m_read_write", 32'(bus.m_read_write), 32'(0));
        chk("noise_grant", 32'(grant), 32'(2'b01));
        chk("noise_m_en", 32'(bus.m_en), 32'(1));
        push_d(2'b01, 8'hA5, 1'b0);
        pulse_done(8'h99, 2'b00);

        // Stray m_done while idle
        repeat (4) @(posedge clk);
        #1;
        bus.m_data_out = 8'h12;
        bus.m_done     = 1'b1;
        @(posedge clk); #1;
        bus.m_done = 1'b0;
        @(negedge clk);
        chk("stray_done", 32'(done), 32'(0));
        chk("stray_rd_data", 32'(rd_data), 32'(8'hA5));
        chk("stray_grant", 32'(grant), 32'(0));

        // Reset in the middle of a transaction
        set_req(1, 7'h05, 8'h06, 1'b0);
        set_req(0, 7'h0A, 8'h0B, 1'b0);
        push_g(2'b10, 7'h05, 8'h06, 1'b0);
        req = 2'b10;
        wait_grant();
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        push_g(2'b01, 7'h0A, 8'h0B, 1'b0);
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'(0));
        chk("midrst_m_en", 32'(bus.m_en), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_rd_data", 32'(rd_data), 32'(0));
        wait_grant();
        repeat (2) @(posedge clk);
        push_d(2'b01, 8'h00, 1'b0);
        pulse_done(8'h00, 2'b11);

        // Master never completes
        set_req(1, 7'h40, 8'h41, 1'b0);
        push_g(2'b10, 7'h40, 8'h41, 1'b0);
        req = 2'b10;
        wait_grant();
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int n = 0;
            push_d(2'b10, 8'h00, 1'b1);
            do begin
                @(negedge clk);
                n++;
            end while (done == 2'b00 && n < 40);
            req = 2'b00;
            chk("timeout_latency", 32'(n), 32'(16));
            chk("timeout_err", 32'(err), 32'(1));
            chk("timeout_m_en", 32'(bus.m_en), 32'(0));
            chk("timeout_rd_data", 32'(rd_data), 32'(0));
        end
`else
        repeat (1000) @(negedge clk);
        chk("hang_grant", 32'(grant), 32'(2'b10));
        chk("hang_m_en", 32'(bus.m_en), 32'(1));
        chk("hang_err", 32'(err), 32'(0));
        chk("hang_done", 32'(done), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("grant_queue_empty", 32'(gq.size()), 32'(0));
        chk("done_queue_empty", 32'(dq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
